ram_sdp_pipe: RTL

Parametrised simple dual-port RAM with byte-enable writes, configurable read latency, a read-valid pipeline and byte-granular write-to-read forwarding. It is the general-purpose successor to the fixed-width, two-cycle, no-reset SDP RAM. It serves as the storage primitive under line buffers, FIFOs and register files that need deterministic read-during-write results and a qualified read stream.

---
 rtl/ram_sdp_pipe.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ram_sdp_pipe.sv
// Simple dual-port RAM: byte-enable writes, registered reads, qualified read stream.
// Latency: a read captured at edge t presents q/q_valid at edge t+LATENCY (LATENCY 2..5).
// Backpressure: none; one read and one write may be accepted every cycle, results in order.
//
// Ports:
//   clock      - single clock, rising edge
//   reset_n    - asynchronous active-low reset (clears read/forward pipelines and q)
//   wren, wraddress, byteena, data - write port; byteena[i] covers data lane i
//   rden, rdaddress                - read request port
//   q, q_valid                     - read result; q holds its value while q_valid=0
//
// Build option: define RAM_SDP_PIPE_FORWARD_EN to include same-edge write-to-read
// forwarding (full write-first behaviour). Without it, lanes written at the same
// edge and address as a read are undefined in that read's result.

module ram_sdp_pipe #(
    parameter int BUS_WIDTH  = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2,
    parameter     INITFILE   = "UNUSED"
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            wren,
    input  logic [ADDR_WIDTH-1:0]           wraddress,
    input  logic [BUS_WIDTH/BYTE_WIDTH-1:0] byteena,
    input  logic [BUS_WIDTH-1:0]            data,
    input  logic                            rden,
    input  logic [ADDR_WIDTH-1:0]           rdaddress,
    output logic [BUS_WIDTH-1:0]            q,
    output logic                            q_valid
);

    localparam int NUM_BYTES = BUS_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    // ------------------------------------------------------------------
    // Storage array. Not reset: contents survive reset_n assertion.
    // ------------------------------------------------------------------
    logic [BUS_WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_addr_r;
    logic [BUS_WIDTH-1:0]  arr_q;
    logic                  wr_go;

    // Writes are suppressed while reset is held; kept as a separate net so the
    // array flops see a plain enable rather than the async reset itself.
    assign wr_go = wren & reset_n;

    // Initialisation contents are applied by the vendor array wrapper that
    // replaces this generic model; the name is only carried through here.
    if (INITFILE != "UNUSED") begin : g_initfile
    end

    always_ff @(posedge clock) begin : array_write
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (wr_go && byteena[i]) begin
                mem[wraddress][i*BYTE_WIDTH +: BYTE_WIDTH] <= data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Address registered at the capture edge, array output registered one
    // edge later. The array alone is only trusted for writes at earlier edges.
    logic rd_vld_s1;
    logic rd_vld_s2;

    always_ff @(posedge clock) begin : array_read
        if (rden) begin
            rd_addr_r <= rdaddress;
        end
        if (rd_vld_s1) begin
            arr_q <= mem[rd_addr_r];
        end
    end

    // ------------------------------------------------------------------
    // Read-valid pipeline aligned with the array: s1 = address stage,
    // s2 = array output stage.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_s1 <= 1'b0;
            rd_vld_s2 <= 1'b0;
        end else begin
            rd_vld_s1 <= rden;
            rd_vld_s2 <= rd_vld_s1;
        end
    end

    // ------------------------------------------------------------------
    // Lane merge between array output and a same-edge colliding write.
    // ------------------------------------------------------------------
    logic [BUS_WIDTH-1:0] merged;

`ifdef RAM_SDP_PIPE_FORWARD_EN
    // Only the write on the capture edge can collide with a read, so a single
    // two-deep record is enough. The hit flag is folded into the lane mask:
    // a zero mask means "no collision".
    logic                 fwd_hit;
    logic [NUM_BYTES-1:0] fwd_be_s1;
    logic [NUM_BYTES-1:0] fwd_be_s2;
    logic [BUS_WIDTH-1:0] fwd_dat_s1;
    logic [BUS_WIDTH-1:0] fwd_dat_s2;

    assign fwd_hit = wren && rden && (wraddress == rdaddress);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fwd_be_s1  <= '0;
            fwd_be_s2  <= '0;
            fwd_dat_s1 <= '0;
            fwd_dat_s2 <= '0;
        end else begin
            fwd_be_s1 <= fwd_hit ? byteena : '0;
            if (fwd_hit) begin
                fwd_dat_s1 <= data;
            end
            fwd_be_s2  <= fwd_be_s1;
            fwd_dat_s2 <= fwd_dat_s1;
        end
    end

    always_comb begin
        merged = arr_q;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (fwd_be_s2[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = fwd_dat_s2[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end
`else
    assign merged = arr_q;
`endif

    // ------------------------------------------------------------------
    // Output pipeline: stage 0 registers the merged word (edge t+2), the
    // remaining LATENCY-2 stages are plain delay. Data stages load only with
    // a valid, so q holds between results.
    // ------------------------------------------------------------------
    logic [LATENCY-2:0][BUS_WIDTH-1:0] out_dat;
    logic [LATENCY-2:0]                out_vld;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_dat <= '0;
            out_vld <= '0;
        end else begin
            out_vld[0] <= rd_vld_s2;
            if (rd_vld_s2) begin
                out_dat[0] <= merged;
            end
            for (int k = 1; k < LATENCY - 1; k++) begin
                out_vld[k] <= out_vld[k-1];
                if (out_vld[k-1]) begin
                    out_dat[k] <= out_dat[k-1];
                end
            end
        end
    end

    assign q       = out_dat[LATENCY-2];
    assign q_valid = out_vld[LATENCY-2];

endmodule
